// File: rtl/avg_ram_ctrl_pkg.sv
// Shared types and default sizing for the temperature averaging sequencer.
// The AVG_ROUND_EN build option is consumed by avg_accum.
package avg_ram_ctrl_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_LOG2_SAMPLES = 2;
    localparam int DEF_ADDR_W       = 11;
    localparam int SAMPLES          = 1 << DEF_LOG2_SAMPLES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/avg_ram_ctrl_accum.sv
// Sum register, sample counter and divide logic for one averaging group.
// Build option AVG_ROUND_EN selects round-half-up with saturation.
module avg_accum
    import avg_ram_ctrl_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              i_latch,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_last,
    output logic              o_count_nz,
    output logic [DATA_W-1:0] o_din
);

    localparam int SUM_W = DATA_W + LOG2_SAMPLES;
    localparam int HALF  = (1 << LOG2_SAMPLES) / 2;

    logic [SUM_W-1:0]        r_sum;
    logic [LOG2_SAMPLES-1:0] r_count;
    logic [DATA_W-1:0]       r_din;
    logic [SUM_W-1:0]        w_sum_next;
    logic [DATA_W-1:0]       w_avg;

    assign w_sum_next = r_sum + SUM_W'(i_data);
    assign o_last     = &r_count;
    assign o_count_nz = |r_count;
    assign o_din      = r_din;

`ifdef AVG_ROUND_EN
    logic [SUM_W:0]  w_round;
    logic [DATA_W:0] w_quot;

    assign w_round = {1'b0, w_sum_next} + (SUM_W+1)'(HALF);
    assign w_quot  = (DATA_W+1)'(w_round >> LOG2_SAMPLES);
    assign w_avg   = w_quot[DATA_W] ? '1 : w_quot[DATA_W-1:0];
`else
    assign w_avg = DATA_W'(w_sum_next >> LOG2_SAMPLES);
`endif

    // The result is registered on the last sample so it is stable during WRITE.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_sum   <= '0;
            r_count <= '0;
            r_din   <= '0;
        end else if (i_latch) begin
            r_sum   <= w_sum_next;
            r_count <= o_last ? '0 : r_count + 1'b1;
            if (o_last) begin
                r_din <= w_avg;
            end
        end else if (i_write) begin
            r_sum <= '0;
        end
    end

endmodule

// File: rtl/avg_ram_ctrl.sv
// FIFO-to-RAM averaging sequencer: pops bytes, averages groups, writes RAM.
// Build option AVG_ROUND_EN enables rounded averages (see avg_accum).
module avg_ram_ctrl
    import avg_ram_ctrl_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wrap,
    output logic              busy
);

    state_t            r_state;
    logic              r_fifo_rd;
    logic              r_ram_wr;
    logic              r_ram_wrap;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last;
    logic              w_count_nz;

    avg_accum #(
        .DATA_W       (DATA_W),
        .LOG2_SAMPLES (LOG2_SAMPLES)
    ) u_accum (
        .clk_2      (clk_2),
        .reset      (reset),
        .i_latch    (r_state == LATCH),
        .i_write    (r_state == WRITE),
        .i_data     (fifo_dout),
        .o_last     (w_last),
        .o_count_nz (w_count_nz),
        .o_din      (ram_din)
    );

    // LATCH and WRITE fold the idle empty-check into their exit so a
    // non-empty FIFO streams at two cycles per sample.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fifo_rd  <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_ram_wrap <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_ram_wrap <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!fifo_empty) begin
                        r_state   <= POP;
                        r_fifo_rd <= 1'b1;
                    end
                end
                POP: begin
                    r_state   <= LATCH;
                    r_fifo_rd <= 1'b0;
                end
                LATCH: begin
                    if (w_last) begin
                        r_state  <= WRITE;
                        r_ram_wr <= 1'b1;
                    end else if (!fifo_empty) begin
                        r_state   <= POP;
                        r_fifo_rd <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    r_ram_wr   <= 1'b0;
                    r_addr     <= r_addr + 1'b1;
                    r_ram_wrap <= &r_addr;
                    if (!fifo_empty) begin
                        r_state   <= POP;
                        r_fifo_rd <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd  = r_fifo_rd;
    assign ram_wr   = r_ram_wr;
    assign ram_wrap = r_ram_wrap;
    assign ram_addr = r_addr;
    assign busy     = w_count_nz || (r_state == WRITE);

endmodule

// File: tb/tb_avg_ram_ctrl.sv
// Randomized bench for avg_ram_ctrl against a byte-stream averaging model.
module tb_avg_ram_ctrl;

    localparam int DW    = 8;
    localparam int LS    = 2;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk_2 = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wrap;
    logic          busy;

    typedef struct {
        int addr;
        int din;
    } exp_t;

    exp_t exp_q[$];
    int   fq[$];
    int   part_q[$];
    int   model_wcnt   = 0;
    int   n_cmp        = 0;
    int   n_bad        = 0;
    int   pop_cnt      = 0;
    int   wrap_cnt     = 0;
    int   exp_wrap_cnt = 0;
    bit   wrap_due     = 0;
    bit   prev_rd      = 0;
    exp_t mon_e;

    avg_ram_ctrl #(
        .DATA_W       (DW),
        .LOG2_SAMPLES (LS),
        .ADDR_W       (AW)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_wrap   (ram_wrap),
        .busy       (busy)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int avg_of(input int s);
`ifdef AVG_ROUND_EN
        int r;
        r = (s + (1 << LS) / 2) / (1 << LS);
        return (r > 255) ? 255 : r;
`else
        return s / (1 << LS);
`endif
    endfunction

    // Behavioural FIFO: data appears the cycle after the pop strobe.
    always @(posedge clk_2) begin
        if (fifo_rd && fq.size() > 0) begin
            fifo_dout <= DW'(fq.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic push(input int b);
        int s;
        fq.push_back(b);
        part_q.push_back(b);
        if (part_q.size() == (1 << LS)) begin
            s = 0;
            foreach (part_q[i]) s += part_q[i];
            exp_q.push_back('{model_wcnt % DEPTH, avg_of(s)});
            if (model_wcnt % DEPTH == DEPTH - 1) exp_wrap_cnt++;
            model_wcnt++;
            part_q.delete();
        end
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        push(a);
        push(b);
        push(c);
        push(d);
    endtask

    task automatic drain(input int budget);
        int n;
        bit to;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < budget) begin
            @(negedge clk_2);
            n++;
        end
        to = (exp_q.size() != 0 || fq.size() != 0 || busy);
        check_eq("drain_timeout", int'(to), 0);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_fifo_rd", fifo_rd, 0);
        check_eq("rst_ram_wr", ram_wr, 0);
        check_eq("rst_ram_wrap", ram_wrap, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_din", ram_din, 0);
    endtask

    always @(negedge clk_2) begin
        if (reset) begin
            pop_cnt  = 0;
            wrap_due = 0;
            prev_rd  = 0;
        end else begin
            if (fifo_rd) begin
                check_eq("rd_back_to_back", int'(prev_rd), 0);
                pop_cnt++;
            end
            prev_rd = fifo_rd;
            if (ram_wrap || wrap_due) check_eq("ram_wrap", ram_wrap, int'(wrap_due));
            if (ram_wrap) wrap_cnt++;
            wrap_due = 0;
            if (ram_wr) begin
                check_eq("pops_per_write", pop_cnt, 1 << LS);
                pop_cnt = 0;
                check_eq("write_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("ram_addr", ram_addr, mon_e.addr);
                    check_eq("ram_din", ram_din, mon_e.din);
                    wrap_due = (mon_e.addr == DEPTH - 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk_2);
        check_reset_vals();

        push4(10, 20, 30, 40);
        @(negedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_2);
            if (ram_wr) begin
                lat = k;
                break;
            end
        end
        check_eq("first_write_latency", lat, 9);
        repeat (5) @(negedge clk_2);
        check_eq("idle_fifo_rd", fifo_rd, 0);
        check_eq("idle_busy", busy, 0);

        push4(1, 2, 2, 2);
        push4(255, 255, 255, 255);
        drain(200);

        push(10);
        push(20);
        while (fq.size() != 0) @(negedge clk_2);
        repeat (20) @(negedge clk_2);
        check_eq("gap_busy", busy, 1);
        check_eq("gap_fifo_rd", fifo_rd, 0);
        push(30);
        push(40);
        drain(200);
        push4($urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
        drain(200);
        check_eq("wrap_count_a", wrap_cnt, exp_wrap_cnt);

        for (int g = 0; g < 10; g++) begin
            push4($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
        end
        drain(1000);

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk_2);
            push($urandom_range(0, 255));
        end
        drain(1000);

        push(200);
        push(100);
        while (fq.size() != 0) @(negedge clk_2);
        repeat (3) @(negedge clk_2);
        check_eq("mid_group_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals();
        part_q.delete();
        exp_q.delete();
        model_wcnt = 0;
        @(negedge clk_2);
        reset = 1'b0;
        push4(8, 8, 8, 8);
        drain(200);
        check_eq("wrap_count_b", wrap_cnt, exp_wrap_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
